// File: rtl/gamepad_pmod_tx_if.sv
// Parallel request handshake into the gamepad Pmod transmitter.
interface gamepad_pmod_tx_if #(
    parameter int unsigned BIT_WIDTH = 12
);
    logic [BIT_WIDTH-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/gamepad_pmod_tx.sv
// Gamepad Pmod transmitter: serialises a button word MSB first as
// data/clock pairs followed by a latch pulse and an idle gap.
module gamepad_pmod_tx #(
    parameter int unsigned BIT_WIDTH   = 12,
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    gamepad_pmod_tx_if.slave   tx,
    output logic               pmod_data,
    output logic               pmod_clk,
    output logic               pmod_latch,
    output logic               frame_done
);

    localparam int unsigned PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int unsigned BW = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
    localparam logic [PW-1:0] PH_LOAD  = PW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LOAD = BW'(BIT_WIDTH - 1);

    // Receiver synchroniser plus edge detect needs at least three cycles per phase.
    if (HALF_PERIOD < 3) begin : g_half_period_check
        $error("gamepad_pmod_tx: HALF_PERIOD must be >= 3");
    end
    if (BIT_WIDTH < 2) begin : g_bit_width_check
        $error("gamepad_pmod_tx: BIT_WIDTH must be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CLK_HIGH,
        S_LATCH,
        S_GAP
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_phase;
    logic [BW-1:0]       r_bit;
    logic [BIT_WIDTH-2:0] r_shift;
    logic                r_data;
    logic                r_clk;
    logic                r_latch;
    logic                r_done;
    logic                r_ready;

    logic w_phase_end;
    assign w_phase_end = (r_phase == '0);

    // MSB goes straight to pmod_data on accept; r_shift holds the bits still to send.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= 1'b0;
            r_clk   <= 1'b0;
            r_latch <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tx.tx_valid) begin
                        r_shift <= tx.tx_data[BIT_WIDTH-2:0];
                        r_data  <= tx.tx_data[BIT_WIDTH-1];
                        r_bit   <= BIT_LOAD;
                        r_phase <= PH_LOAD;
                        r_ready <= 1'b0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_phase_end) begin
                        r_clk   <= 1'b1;
                        r_phase <= PH_LOAD;
                        r_state <= S_CLK_HIGH;
                    end else begin
                        r_phase <= r_phase - PW'(1);
                    end
                end
                S_CLK_HIGH: begin
                    if (w_phase_end) begin
                        r_clk   <= 1'b0;
                        r_phase <= PH_LOAD;
                        if (r_bit != '0) begin
                            r_bit   <= r_bit - BW'(1);
                            r_data  <= r_shift[BIT_WIDTH-2];
                            r_shift <= r_shift << 1;
                            r_state <= S_SETUP;
                        end else begin
                            r_data  <= 1'b0;
                            r_latch <= 1'b1;
                            r_state <= S_LATCH;
                        end
                    end else begin
                        r_phase <= r_phase - PW'(1);
                    end
                end
                S_LATCH: begin
                    if (w_phase_end) begin
                        r_latch <= 1'b0;
                        r_phase <= PH_LOAD;
                        r_state <= S_GAP;
                    end else begin
                        r_phase <= r_phase - PW'(1);
                    end
                end
                S_GAP: begin
                    if (w_phase_end) begin
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_phase <= r_phase - PW'(1);
                    end
                end
                default: begin
                    r_data  <= 1'b0;
                    r_clk   <= 1'b0;
                    r_latch <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx.tx_ready = r_ready;
    assign pmod_data   = r_data;
    assign pmod_clk    = r_clk;
    assign pmod_latch  = r_latch;
    assign frame_done  = r_done;

endmodule
